dma_desc_issuer: RTL and testbench

Single-channel descriptor-bypass issuer that sits directly upstream of the XDMA wrapper's `c2h_dsc_byp_*` / `h2c_dsc_byp_*` port group (one instance per channel and direction). It accepts one DMA command (host address, byte length) at a time and splits it into boundary-aligned chunks. It drives each chunk as a descriptor load. It then tracks the matching stream beats on that channel's AXI-Stream interface until the command is fully transferred.

---
 rtl/dma_pkg.sv | 32 +++
 rtl/dma_desc_issuer.sv | 102 ++++++++++
 tb/tb_dma_desc_issuer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/dma_pkg.sv
// Shared DMA types: issuer FSM states, command record and the chunk splitter.
// Latency: none (types and a pure combinational function).
// Backpressure: n/a.
package dma_pkg;

   localparam int unsigned BEAT_BYTES_DEF = 64;
   localparam int unsigned MAX_CHUNK_DEF  = 4096;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ISSUE     = 2'd1,
      ST_WAIT_DATA = 2'd2,
      ST_DONE      = 2'd3
   } issuer_state_t;

   typedef struct packed {
      logic [63:0] addr;
      logic [31:0] len;
   } dma_cmd_t;

   // Largest piece starting at addr that neither overruns the command nor
   // crosses a max_chunk boundary. max_chunk is a power of two <= 2^27, so
   // only the low 32 address bits take part in the offset.
   function automatic logic [31:0] chunk_len(input logic [63:0] addr,
                                             input logic [31:0] remaining,
                                             input logic [31:0] max_chunk);
      logic [31:0] room;
      room = max_chunk - (addr[31:0] & (max_chunk - 32'd1));
      return (remaining < room) ? remaining : room;
   endfunction

endpackage

// File: rtl/dma_desc_issuer.sv
// Splits one DMA command into boundary-aligned bypass descriptors and counts the matching stream beats.
// Latency: first descriptor the cycle after command accept; cmd_done the cycle after the last beat.
// Backpressure: one command at a time (s_cmd_ready only in IDLE); loads stall while dsc_byp_ready is low.
module dma_desc_issuer
   import dma_pkg::*;
#(
   parameter int unsigned MAX_CHUNK  = MAX_CHUNK_DEF,
   parameter int unsigned BEAT_BYTES = BEAT_BYTES_DEF
) (
   input  logic        pcie_clk,
   input  logic        pcie_aresetn,
   input  logic        s_cmd_valid,
   output logic        s_cmd_ready,
   input  logic [63:0] s_cmd_addr,
   input  logic [31:0] s_cmd_len,
   input  logic        dsc_byp_ready,
   output logic [63:0] dsc_byp_addr,
   output logic [31:0] dsc_byp_len,
   output logic        dsc_byp_load,
   input  logic        beat_fire,
   output logic        cmd_done,
   output logic        busy,
   output logic        err_extra_beat
);

   localparam logic [31:0] MAX_CHUNK_W  = 32'(MAX_CHUNK);
   localparam logic [31:0] BEAT_BYTES_W = 32'(BEAT_BYTES);

   issuer_state_t state;
   logic [63:0]   cur_addr;
   logic [31:0]   remaining;
   logic [31:0]   exp_beats;
   logic [31:0]   got_beats;

   dma_cmd_t      cmd;
   logic [31:0]   chunk;
   logic [31:0]   chunk_beats;
   logic [31:0]   got_nxt;
   logic          cmd_fire;
   logic          beat_ok;
   logic          beat_bad;

   assign cmd         = '{addr: s_cmd_addr, len: s_cmd_len};
   assign chunk       = chunk_len(cur_addr, remaining, MAX_CHUNK_W);
   // chunk <= 2^27, so the rounding add cannot overflow 32 bits.
   assign chunk_beats = (chunk + BEAT_BYTES_W - 32'd1) / BEAT_BYTES_W;

   // Beats count only while data can legitimately be outstanding.
   assign beat_ok  = beat_fire && (state == ST_ISSUE || state == ST_WAIT_DATA)
                     && !(got_beats == exp_beats && remaining == 32'd0);
   assign beat_bad = beat_fire && !beat_ok;
   assign got_nxt  = got_beats + {31'd0, beat_ok};

   // Reset gates ready and load so nothing is accepted or issued in the reset cycle.
   assign s_cmd_ready  = pcie_aresetn && (state == ST_IDLE);
   assign cmd_fire     = s_cmd_valid && s_cmd_ready;
   assign dsc_byp_load = pcie_aresetn && (state == ST_ISSUE) && dsc_byp_ready;
   assign dsc_byp_addr = cur_addr;
   assign dsc_byp_len  = chunk;
   assign cmd_done     = (state == ST_DONE);
   assign busy         = (state != ST_IDLE);

   // Command FSM, address/length walk and beat accounting.
   always_ff @(posedge pcie_clk) begin
      if (!pcie_aresetn) begin
         state          <= ST_IDLE;
         cur_addr       <= '0;
         remaining      <= '0;
         exp_beats      <= '0;
         got_beats      <= '0;
         err_extra_beat <= 1'b0;
      end else begin
         if (beat_ok)  got_beats      <= got_nxt;
         if (beat_bad) err_extra_beat <= 1'b1;
         case (state)
            ST_IDLE: begin
               if (cmd_fire) begin
                  cur_addr  <= cmd.addr;
                  remaining <= cmd.len;
                  exp_beats <= '0;
                  got_beats <= '0;
                  state     <= (cmd.len != 32'd0) ? ST_ISSUE : ST_DONE;
               end
            end
            ST_ISSUE: begin
               if (dsc_byp_load) begin
                  cur_addr  <= cur_addr + {32'd0, chunk};
                  remaining <= remaining - chunk;
                  exp_beats <= exp_beats + chunk_beats;
                  if (remaining == chunk) state <= ST_WAIT_DATA;
               end
            end
            ST_WAIT_DATA: begin
               // Look at the post-beat count so DONE follows the last beat directly.
               if (got_nxt == exp_beats) state <= ST_DONE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dma_desc_issuer.sv
// Self-checking bench for dma_desc_issuer: directed and random commands against a chunk-list model.
// Latency: n/a (testbench).
// Backpressure: randomised dsc_byp_ready; beats issued only for descriptors already loaded.
module tb_dma_desc_issuer;

   logic        pcie_clk = 1'b0;
   logic        pcie_aresetn;
   logic        s_cmd_valid;
   logic        s_cmd_ready;
   logic [63:0] s_cmd_addr;
   logic [31:0] s_cmd_len;
   logic        dsc_byp_ready;
   logic [63:0] dsc_byp_addr;
   logic [31:0] dsc_byp_len;
   logic        dsc_byp_load;
   logic        beat_fire;
   logic        cmd_done;
   logic        busy;
   logic        err_extra_beat;

   int passed = 0;
   int total  = 0;
   logic exp_err = 1'b0;

   dma_desc_issuer #(.MAX_CHUNK(4096), .BEAT_BYTES(64)) dut (
      .pcie_clk       (pcie_clk),
      .pcie_aresetn   (pcie_aresetn),
      .s_cmd_valid    (s_cmd_valid),
      .s_cmd_ready    (s_cmd_ready),
      .s_cmd_addr     (s_cmd_addr),
      .s_cmd_len      (s_cmd_len),
      .dsc_byp_ready  (dsc_byp_ready),
      .dsc_byp_addr   (dsc_byp_addr),
      .dsc_byp_len    (dsc_byp_len),
      .dsc_byp_load   (dsc_byp_load),
      .beat_fire      (beat_fire),
      .cmd_done       (cmd_done),
      .busy           (busy),
      .err_extra_beat (err_extra_beat)
   );

   always #5 pcie_clk = ~pcie_clk;

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      total++;
      assert (observed === expected) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
   endtask

   // Issue one command and follow it to completion. Expected descriptors come
   // from walking the byte range in plain arithmetic; beats are only offered
   // for descriptors already seen loading. hold = cycles of forced ready-low.
   task automatic run_cmd(input logic [63:0] a, input logic [31:0] l,
                          input int rdy_pct, input int hold);
      logic [63:0] qa[$];
      logic [31:0] ql[$];
      logic [63:0] pa;
      longint      pr, room, c;
      int          beats_total, avail, sent, cyc;
      bit          done_next, seen_done;

      pa = a; pr = longint'(l); beats_total = 0;
      while (pr > 0) begin
         room = 4096 - longint'(pa % 64'd4096);
         c    = (pr < room) ? pr : room;
         qa.push_back(pa);
         ql.push_back(32'(c));
         beats_total += int'((c + 63) / 64);
         pa = pa + 64'(c);
         pr = pr - c;
      end

      s_cmd_valid = 1'b1; s_cmd_addr = a; s_cmd_len = l;
      @(negedge pcie_clk);
      check("cmd_ready_idle", {63'd0, s_cmd_ready}, 64'd1);
      @(posedge pcie_clk); #1;
      s_cmd_valid = 1'b0;

      done_next = (beats_total == 0);
      seen_done = 1'b0; avail = 0; sent = 0; cyc = 0;
      while (!seen_done && cyc < 3000) begin
         dsc_byp_ready = (cyc < hold) ? 1'b0 : ($urandom_range(99) < rdy_pct);
         beat_fire     = (sent < avail) && ($urandom_range(3) != 0);
         @(negedge pcie_clk);
         check("busy", {63'd0, busy}, 64'd1);
         check("cmd_done", {63'd0, cmd_done}, {63'd0, done_next});
         check("load", {63'd0, dsc_byp_load}, {63'd0, (dsc_byp_ready && qa.size() > 0)});
         if (qa.size() > 0) begin
            check("dsc_addr", dsc_byp_addr, qa[0]);
            check("dsc_len", {32'd0, dsc_byp_len}, {32'd0, ql[0]});
            if (dsc_byp_load) begin
               avail += int'((ql[0] + 32'd63) / 32'd64);
               void'(qa.pop_front());
               void'(ql.pop_front());
            end
         end
         if (cmd_done) seen_done = 1'b1;
         if (beat_fire) sent++;
         done_next = beat_fire && (sent == beats_total);
         @(posedge pcie_clk); #1;
         cyc++;
      end
      beat_fire = 1'b0; dsc_byp_ready = 1'b0;
      if (!seen_done) check("done_timeout", 64'd0, 64'd1);
      check("all_desc_loaded", 64'(qa.size()), 64'd0);
      check("all_beats_sent", 64'(sent), 64'(beats_total));
      @(negedge pcie_clk);
      check("ready_after_done", {63'd0, s_cmd_ready}, 64'd1);
      check("idle_not_busy", {63'd0, busy}, 64'd0);
      check("done_one_cycle", {63'd0, cmd_done}, 64'd0);
      check("err_sticky", {63'd0, err_extra_beat}, {63'd0, exp_err});
      @(posedge pcie_clk); #1;
   endtask

   initial begin
      pcie_aresetn = 1'b0; s_cmd_valid = 1'b0; s_cmd_addr = '0; s_cmd_len = '0;
      dsc_byp_ready = 1'b0; beat_fire = 1'b0;
      repeat (3) @(posedge pcie_clk);
      @(negedge pcie_clk);
      check("rst_ready", {63'd0, s_cmd_ready}, 64'd0);
      check("rst_load", {63'd0, dsc_byp_load}, 64'd0);
      check("rst_addr", dsc_byp_addr, 64'd0);
      check("rst_len", {32'd0, dsc_byp_len}, 64'd0);
      check("rst_done", {63'd0, cmd_done}, 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_err", {63'd0, err_extra_beat}, 64'd0);
      @(posedge pcie_clk); #1;
      pcie_aresetn = 1'b1;
      @(negedge pcie_clk);
      check("ready_after_rst", {63'd0, s_cmd_ready}, 64'd1);
      @(posedge pcie_clk); #1;

      // Directed commands: single chunk, boundary split, three-way split, ready stall.
      run_cmd(64'h1000, 32'd256, 100, 0);
      run_cmd(64'h0F00, 32'h300, 100, 0);
      run_cmd(64'h0, 32'd10000, 50, 0);
      run_cmd(64'h1F80, 32'h200, 100, 5);
      // Address wrap past 2^64.
      run_cmd(64'hFFFF_FFFF_FFFF_FF00, 32'h300, 70, 0);

      // Zero-length command, then a stray beat in IDLE.
      run_cmd(64'h1234, 32'd0, 100, 0);
      beat_fire = 1'b1;
      @(negedge pcie_clk);
      check("err_before_edge", {63'd0, err_extra_beat}, 64'd0);
      @(posedge pcie_clk); #1;
      beat_fire = 1'b0;
      exp_err = 1'b1;
      repeat (3) @(posedge pcie_clk);
      @(negedge pcie_clk);
      check("err_set", {63'd0, err_extra_beat}, 64'd1);
      @(posedge pcie_clk); #1;

      // Random commands.
      for (int i = 0; i < 4; i++) begin
         run_cmd({32'd0, $urandom}, 32'($urandom_range(12000, 1)), 60, int'($urandom_range(3)));
      end

      // Reset after the second of three loads.
      dsc_byp_ready = 1'b1;
      s_cmd_valid = 1'b1; s_cmd_addr = 64'h0; s_cmd_len = 32'd12288;
      @(posedge pcie_clk); #1;
      s_cmd_valid = 1'b0;
      @(negedge pcie_clk);
      check("rst_mid_load1", {63'd0, dsc_byp_load}, 64'd1);
      check("rst_mid_addr1", dsc_byp_addr, 64'h0);
      @(posedge pcie_clk); #1;
      @(negedge pcie_clk);
      check("rst_mid_load2", {63'd0, dsc_byp_load}, 64'd1);
      check("rst_mid_addr2", dsc_byp_addr, 64'h1000);
      @(posedge pcie_clk); #1;
      pcie_aresetn = 1'b0;
      @(negedge pcie_clk);
      check("rst_mid_no_load", {63'd0, dsc_byp_load}, 64'd0);
      @(posedge pcie_clk); #1;
      @(negedge pcie_clk);
      check("rst_mid_busy", {63'd0, busy}, 64'd0);
      check("rst_mid_load", {63'd0, dsc_byp_load}, 64'd0);
      check("rst_mid_addr", dsc_byp_addr, 64'd0);
      check("rst_mid_len", {32'd0, dsc_byp_len}, 64'd0);
      check("rst_mid_done", {63'd0, cmd_done}, 64'd0);
      check("rst_mid_err", {63'd0, err_extra_beat}, 64'd0);
      check("rst_mid_ready", {63'd0, s_cmd_ready}, 64'd0);
      @(posedge pcie_clk); #1;
      pcie_aresetn = 1'b1; dsc_byp_ready = 1'b0;
      exp_err = 1'b0;
      run_cmd(64'h5040, 32'h1000, 80, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
